// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bus: tick/button/select inputs and registered display outputs.
// master drives the inputs and observes the outputs; slave is the controller side.
interface stopwatch_ctrl_if;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       tick_blink;
    logic       btn_pause;
    logic       btn_adj;
    logic       sel;
    logic       btn_lap;
    logic [2:0] state;
    logic [5:0] disp_min;
    logic [5:0] disp_sec;
    logic       blank_min;
    logic       blank_sec;
    logic       lap_active;

    modport master (
        output tick_1hz, tick_2hz, tick_blink, btn_pause, btn_adj, sel, btn_lap,
        input  state, disp_min, disp_sec, blank_min, blank_sec, lap_active
    );

    modport slave (
        input  tick_1hz, tick_2hz, tick_blink, btn_pause, btn_adj, sel, btn_lap,
        output state, disp_min, disp_sec, blank_min, blank_sec, lap_active
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM with mm:ss counter, field adjust, and blink blanking.
// Optional lap hold on the display is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
    parameter int unsigned MAX_MIN = 59
) (
    input logic              clk,
    input logic              rst,
    stopwatch_ctrl_if.slave  bus
);
    localparam logic [2:0] RUN     = 3'b000;
    localparam logic [2:0] PAUSE   = 3'b001;
    localparam logic [2:0] ADJ_MIN = 3'b010;
    localparam logic [2:0] ADJ_SEC = 3'b011;
    localparam logic [5:0] MIN_TOP = 6'(MAX_MIN);
    localparam logic [5:0] SEC_TOP = 6'd59;

    logic [2:0] state_q, state_d;
    logic [5:0] min_q, min_d, sec_q, sec_d;
    logic [5:0] disp_min_q, disp_min_d, disp_sec_q, disp_sec_d;
    logic       phase_q, phase_d;
    logic       blank_min_q, blank_min_d, blank_sec_q, blank_sec_d;
    logic       lap_q, lap_d;
    logic       prev_pause, prev_adj, armed;
    logic       pause_edge, adj_edge, in_adj;

    // armed stays low for the first clock after reset so a button held through
    // reset release only loads its history instead of producing an edge.
    assign pause_edge = armed & bus.btn_pause & ~prev_pause;
    assign adj_edge   = armed & bus.btn_adj   & ~prev_adj;
    assign in_adj     = state_q[1];

`ifdef STOPWATCH_LAP_EN
    logic prev_lap, lap_edge;
    assign lap_edge = armed & bus.btn_lap & ~prev_lap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_lap <= 1'b0;
        else     prev_lap <= bus.btn_lap;
    end
`endif

    always_comb begin
        state_d = state_q;
        if (adj_edge)
            state_d = in_adj ? PAUSE : (bus.sel ? ADJ_SEC : ADJ_MIN);
        else if (pause_edge && !in_adj)
            state_d = (state_q == RUN) ? PAUSE : RUN;
        else if (in_adj)
            state_d = bus.sel ? ADJ_SEC : ADJ_MIN;
    end

    // Counting uses the registered state so a coincident transition does not affect this tick.
    always_comb begin
        min_d = min_q;
        sec_d = sec_q;
        case (state_q)
            RUN: if (bus.tick_1hz) begin
                if (sec_q == SEC_TOP) begin
                    sec_d = '0;
                    min_d = (min_q == MIN_TOP) ? '0 : min_q + 6'd1;
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end
            ADJ_MIN: if (bus.tick_2hz) min_d = (min_q == MIN_TOP) ? '0 : min_q + 6'd1;
            ADJ_SEC: if (bus.tick_2hz) sec_d = (sec_q == SEC_TOP) ? '0 : sec_q + 6'd1;
            default: ;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        if (state_d[1] && !in_adj) phase_d = 1'b0;
        else if (bus.tick_blink)   phase_d = ~phase_q;
        blank_min_d = (state_d == ADJ_MIN) & phase_d;
        blank_sec_d = (state_d == ADJ_SEC) & phase_d;
    end

    always_comb begin
`ifdef STOPWATCH_LAP_EN
        lap_d = lap_q;
        if (state_q == RUN && state_d != RUN) lap_d = 1'b0;
        else if (state_q == RUN && lap_edge)  lap_d = ~lap_q;
        disp_min_d = lap_d ? disp_min_q : min_d;
        disp_sec_d = lap_d ? disp_sec_q : sec_d;
`else
        lap_d      = 1'b0;
        disp_min_d = min_d;
        disp_sec_d = sec_d;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PAUSE;
            min_q       <= '0;
            sec_q       <= '0;
            disp_min_q  <= '0;
            disp_sec_q  <= '0;
            phase_q     <= 1'b0;
            blank_min_q <= 1'b0;
            blank_sec_q <= 1'b0;
            lap_q       <= 1'b0;
            prev_pause  <= 1'b0;
            prev_adj    <= 1'b0;
            armed       <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            disp_min_q  <= disp_min_d;
            disp_sec_q  <= disp_sec_d;
            phase_q     <= phase_d;
            blank_min_q <= blank_min_d;
            blank_sec_q <= blank_sec_d;
            lap_q       <= lap_d;
            prev_pause  <= bus.btn_pause;
            prev_adj    <= bus.btn_adj;
            armed       <= 1'b1;
        end
    end

    assign bus.state      = state_q;
    assign bus.disp_min   = disp_min_q;
    assign bus.disp_sec   = disp_sec_q;
    assign bus.blank_min  = blank_min_q;
    assign bus.blank_sec  = blank_sec_q;
    assign bus.lap_active = lap_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with hand-computed expectations.
// Lap-hold expectations depend on whether STOPWATCH_LAP_EN is defined.
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    localparam logic [5:0] P_TICK1 = 6'b000001;
    localparam logic [5:0] P_TICK2 = 6'b000010;
    localparam logic [5:0] P_BLINK = 6'b000100;
    localparam logic [5:0] P_PAUSE = 6'b001000;
    localparam logic [5:0] P_ADJ   = 6'b010000;
    localparam logic [5:0] P_LAP   = 6'b100000;

    stopwatch_ctrl_if bus();

    stopwatch_ctrl #(.MAX_MIN(59)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_disp(input string tag, input int m, input int s);
        check({tag, "_min"}, 16'(bus.disp_min), 16'(m));
        check({tag, "_sec"}, 16'(bus.disp_sec), 16'(s));
    endtask

    // One-cycle pulse on the selected inputs; returns at the negedge after the capturing posedge.
    task automatic pulse(input logic [5:0] mask);
        @(negedge clk);
        bus.tick_1hz   = mask[0];
        bus.tick_2hz   = mask[1];
        bus.tick_blink = mask[2];
        bus.btn_pause  = mask[3];
        bus.btn_adj    = mask[4];
        bus.btn_lap    = mask[5];
        @(negedge clk);
        bus.tick_1hz   = 1'b0;
        bus.tick_2hz   = 1'b0;
        bus.tick_blink = 1'b0;
        bus.btn_pause  = 1'b0;
        bus.btn_adj    = 1'b0;
        bus.btn_lap    = 1'b0;
    endtask

    task automatic pulses(input logic [5:0] mask, input int n);
        for (int i = 0; i < n; i++) pulse(mask);
    endtask

    initial begin
        bus.tick_1hz   = 1'b0;
        bus.tick_2hz   = 1'b0;
        bus.tick_blink = 1'b0;
        bus.btn_pause  = 1'b1;
        bus.btn_adj    = 1'b0;
        bus.sel        = 1'b0;
        bus.btn_lap    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 16'(bus.state), 16'd1);
        check_disp("rst_disp", 0, 0);
        check("rst_blank", 16'({bus.blank_min, bus.blank_sec}), 16'd0);
        check("rst_lap", 16'(bus.lap_active), 16'd0);

        // pause held high across reset release must not act
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("held_btn_no_edge", 16'(bus.state), 16'd1);
        bus.btn_pause = 1'b0;

        pulse(P_PAUSE);
        check("pause_to_run", 16'(bus.state), 16'd0);
        pulses(P_TICK1, 61);
        check("run61_state", 16'(bus.state), 16'd0);
        check_disp("run61", 1, 1);
        pulse(P_TICK2);
        check_disp("tick2_in_run", 1, 1);

        // walk the count to 59:59 through the adjust modes
        pulse(P_ADJ);
        check("adj_min_entry", 16'(bus.state), 16'd2);
        pulses(P_TICK2, 58);
        check_disp("adj_min59", 59, 1);
        bus.sel = 1'b1;
        @(negedge clk);
        check("sel_follow_sec", 16'(bus.state), 16'd3);
        pulses(P_TICK2, 58);
        check_disp("adj_sec59", 59, 59);
        pulse(P_TICK2);
        check_disp("adj_sec_wrap_nocarry", 59, 0);
        pulses(P_TICK2, 59);
        pulse(P_ADJ);
        check("adj_to_pause", 16'(bus.state), 16'd1);
        pulse(P_PAUSE);
        check("pause_to_run2", 16'(bus.state), 16'd0);
        pulse(P_TICK1);
        check_disp("wrap_5959", 0, 0);

        // adjust from pause: seconds then minutes, 1 Hz ignored
        pulse(P_PAUSE);
        check("run_to_pause", 16'(bus.state), 16'd1);
        pulse(P_TICK1);
        check_disp("tick1_in_pause", 0, 0);
        pulse(P_ADJ);
        check("pause_adj_sec", 16'(bus.state), 16'd3);
        pulses(P_TICK2, 3);
        pulse(P_TICK1);
        bus.sel = 1'b0;
        @(negedge clk);
        check("sel_follow_min", 16'(bus.state), 16'd2);
        pulse(P_TICK2);
        check_disp("adj_0103", 1, 3);

        // blink phase in ADJ_SEC
        pulse(P_ADJ);
        check("adj_min_to_pause", 16'(bus.state), 16'd1);
        bus.sel = 1'b1;
        pulse(P_ADJ);
        check("blank_sec_entry", 16'(bus.blank_sec), 16'd0);
        pulse(P_BLINK);
        check("blank_sec_on", 16'(bus.blank_sec), 16'd1);
        check("blank_min_off", 16'(bus.blank_min), 16'd0);
        pulse(P_BLINK);
        check("blank_sec_off", 16'(bus.blank_sec), 16'd0);
        check("blank_min_off2", 16'(bus.blank_min), 16'd0);
        pulse(P_BLINK);
        pulse(P_ADJ);
        check("blink_exit_state", 16'(bus.state), 16'd1);
        check("blink_exit_blanks", 16'({bus.blank_min, bus.blank_sec}), 16'd0);

        // adj beats pause in the same cycle
        bus.sel = 1'b0;
        pulse(P_PAUSE);
        check("pause_to_run3", 16'(bus.state), 16'd0);
        pulse(P_PAUSE | P_ADJ);
        check("adj_priority", 16'(bus.state), 16'd2);
        pulses(P_TICK2, 2);
        check_disp("adj_min_plus2", 3, 3);

        // reset mid-adjust discards everything and holds while asserted
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_state", 16'(bus.state), 16'd1);
        check_disp("async_rst_disp", 0, 0);
        pulse(P_PAUSE | P_TICK1);
        pulse(P_ADJ | P_TICK2);
        check("rst_hold_state", 16'(bus.state), 16'd1);
        check_disp("rst_hold_disp", 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // lap hold
        pulse(P_PAUSE);
        pulses(P_TICK1, 5);
        check_disp("lap_start", 0, 5);
        pulse(P_LAP);
        pulses(P_TICK1, 3);
`ifdef STOPWATCH_LAP_EN
        check("lap_on", 16'(bus.lap_active), 16'd1);
        check_disp("lap_frozen", 0, 5);
        pulse(P_LAP);
        check("lap_off", 16'(bus.lap_active), 16'd0);
        check_disp("lap_release", 0, 8);
        pulse(P_LAP);
        check("lap_on2", 16'(bus.lap_active), 16'd1);
        pulse(P_PAUSE);
        check("lap_clear_on_pause", 16'(bus.lap_active), 16'd0);
        check_disp("lap_clear_disp", 0, 8);
`else
        check("lap_tied", 16'(bus.lap_active), 16'd0);
        check_disp("lap_ignored", 0, 8);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
